// File: rtl/alu_step_controller_pkg.sv
// Shared phase encoding, flag layout and field widths for the ALU step controller.
package alu_step_controller_pkg;

  localparam int OP_W   = 4;
  localparam int FLAG_W = 4;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_NEG   = 1;
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_OVF   = 3;

  typedef enum logic [4:0] {
    PH_A     = 5'b00001,
    PH_B     = 5'b00010,
    PH_OP    = 5'b00100,
    PH_RES   = 5'b01000,
    PH_FLAGS = 5'b10000
  } phase_t;

endpackage

// File: rtl/alu_step_controller_button_debouncer.sv
// Pushbutton conditioner: 2-FF synchronizer, hold-time debounce counter and a
// single-cycle pulse on each accepted press. Reusable for any board button.
module button_debouncer #(
  parameter int DebounceCycles = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  localparam int CntW = $clog2(DebounceCycles);
  localparam logic [CntW-1:0] CNT_LAST = CntW'(DebounceCycles - 1);

  logic            sync_p0;
  logic            sync_p1;
  logic            stable;
  logic            stable_prev;
  logic [CntW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0     <= 1'b0;
      sync_p1     <= 1'b0;
      stable      <= 1'b0;
      stable_prev <= 1'b0;
      count       <= '0;
    end else begin
      sync_p0     <= btn;
      sync_p1     <= sync_p0;
      stable_prev <= stable;
      // Any sample agreeing with the accepted level restarts the hold window.
      if (sync_p1 != stable) begin
        if (count == CNT_LAST) begin
          stable <= sync_p1;
          count  <= '0;
        end else begin
          count <= count + CntW'(1);
        end
      end else begin
        count <= '0;
      end
    end
  end

  // Both terms are registered, so the pulse is glitch-free.
  assign rise = stable & ~stable_prev;

endmodule

// File: rtl/alu_step_controller.sv
// Button-paced operator sequencer for the ALU demo: edits operands/opcode,
// captures the ALU result and flags once per operation, selects the display value.
module alu_step_controller
  import alu_step_controller_pkg::*;
#(
  parameter int Width          = 32,
  parameter int DebounceCycles = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_btn,
  input  logic [Width-1:0]  inputsw,
  input  logic [Width-1:0]  alu_result,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic [Width-1:0]  a,
  output logic [Width-1:0]  b,
  output logic [OP_W-1:0]   op,
  output logic              res_valid,
  output logic [Width-1:0]  display,
  output logic [4:0]        state
);

  logic              step;
  logic [4:0]        state_r;
  logic [Width-1:0]  res_reg;
  logic [FLAG_W-1:0] flags_reg;

  button_debouncer #(
    .DebounceCycles(DebounceCycles)
  ) u_debouncer (
    .clk  (clk),
    .rst  (rst),
    .btn  (step_btn),
    .rise (step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= PH_A;
      a         <= '0;
      b         <= '0;
      op        <= '0;
      res_reg   <= '0;
      flags_reg <= '0;
      res_valid <= 1'b0;
    end else begin
      case (state_r)
        PH_A: begin
          a         <= inputsw;
          res_valid <= 1'b0;
          if (step) state_r <= PH_B;
        end
        PH_B: begin
          b <= inputsw;
          if (step) state_r <= PH_OP;
        end
        PH_OP: begin
          op <= inputsw[OP_W-1:0];
          if (step) state_r <= PH_RES;
        end
        PH_RES: begin
          // Operands are registered, so the ALU has settled by the first RES edge.
          if (!res_valid) begin
            res_reg   <= alu_result;
            flags_reg <= alu_flags;
            res_valid <= 1'b1;
          end
          if (step) state_r <= PH_FLAGS;
        end
        PH_FLAGS: begin
          if (step) begin
            state_r   <= PH_A;
            res_valid <= 1'b0;
          end
        end
        default: state_r <= PH_A;
      endcase
    end
  end

  always_comb begin
    display = '0;
    case (state_r)
      PH_A:     display = a;
      PH_B:     display = b;
      PH_OP:    display = Width'(op);
      PH_RES:   if (res_valid) display = res_reg;
      PH_FLAGS: display = Width'(flags_reg);
      default:  display = '0;
    endcase
  end

  assign state = state_r;

endmodule

// File: tb/tb_alu_step_controller.sv
// Scenario bench for alu_step_controller with a behavioural ALU and result scoreboard.
module tb_alu_step_controller;
  import alu_step_controller_pkg::*;

  localparam int W  = 32;
  localparam int DC = 4;

  typedef struct packed {
    logic [W-1:0] res;
    logic [3:0]   flags;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         step_btn;
  logic [W-1:0] inputsw;
  logic [W-1:0] alu_result;
  logic [3:0]   alu_flags;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   op;
  logic         res_valid;
  logic [W-1:0] display;
  logic [4:0]   state;
  logic         ovr;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t cur;

  always #5 clk = ~clk;

  alu_step_controller #(.Width(W), .DebounceCycles(DC)) dut (
    .clk        (clk),
    .rst        (rst),
    .step_btn   (step_btn),
    .inputsw    (inputsw),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .a          (a),
    .b          (b),
    .op         (op),
    .res_valid  (res_valid),
    .display    (display),
    .state      (state)
  );

  function automatic exp_t alu_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic [3:0] o);
    exp_t       e;
    logic [W:0] wide;
    e.flags = '0;
    wide    = '0;
    case (o)
      4'd0: e.res = x & y;
      4'd1: e.res = x | y;
      4'd2: begin
        wide  = {1'b0, x} + {1'b0, y};
        e.res = wide[W-1:0];
        e.flags[FLAG_CARRY] = wide[W];
        e.flags[FLAG_OVF]   = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
      end
      4'd3: begin
        wide  = {1'b0, x} - {1'b0, y};
        e.res = wide[W-1:0];
        e.flags[FLAG_CARRY] = wide[W];
        e.flags[FLAG_OVF]   = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]);
      end
      4'd4:    e.res = x ^ y;
      default: e.res = x;
    endcase
    e.flags[FLAG_NEG]  = e.res[W-1];
    e.flags[FLAG_ZERO] = (e.res == '0);
    return e;
  endfunction

  // ALU environment; ovr substitutes a different result to expose re-capture.
  assign {alu_result, alu_flags} = ovr ? {32'hDEAD_BEEF, 4'hF} : alu_model(a, b, op);

  initial begin
    #200000;
    $display("FAIL watchdog timeout state=%b", state);
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    @(negedge clk);
    rst      = 1'b1;
    step_btn = 1'b0;
    ovr      = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_step;
    logic [4:0] prev;
    bit         moved;
    step_btn = 1'b0;
    repeat (8) @(negedge clk);
    prev     = state;
    moved    = 1'b0;
    step_btn = 1'b1;
    for (int i = 0; i < 20 && !moved; i++) begin
      @(negedge clk);
      if (state !== prev) moved = 1'b1;
    end
    step_btn = 1'b0;
    checks++;
    if (!moved) begin
      errors++;
      $display("FAIL step_timeout state=%b required a change from %b", state, prev);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; step_btn = 1'b0; inputsw = '0; ovr = 1'b0;
    #12;
    checks++; if (state !== 5'b00001) begin errors++; $display("FAIL reset_state got %b want 00001", state); end
    checks++; if ({a, b, op, res_valid} !== '0) begin errors++; $display("FAIL reset_regs a=%h b=%h op=%h v=%b want 0", a, b, op, res_valid); end
    checks++; if (display !== '0) begin errors++; $display("FAIL reset_display got %h want 0", display); end
    @(negedge clk);
    rst = 1'b0; inputsw = 32'h0000_00AA;
    @(negedge clk);
    checks++; if (a !== 32'hAA) begin errors++; $display("FAIL live_edit_a got %h want aa", a); end
    checks++; if (display !== 32'hAA) begin errors++; $display("FAIL live_edit_display got %h want aa", display); end
  endtask

  task automatic test_bounce;
    for (int r = 0; r < 5; r++) begin
      step_btn = 1'b1; repeat (3) @(negedge clk);
      step_btn = 1'b0; repeat (3) @(negedge clk);
    end
    checks++; if (state !== 5'b00001) begin errors++; $display("FAIL bounce_reject state=%b want 00001", state); end
    step_btn = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (state !== 5'b00001) begin errors++; $display("FAIL step_early state=%b want 00001", state); end
    @(negedge clk);
    checks++; if (state !== 5'b00010) begin errors++; $display("FAIL step_latency state=%b want 00010", state); end
    repeat (20) @(negedge clk);
    checks++; if (state !== 5'b00010) begin errors++; $display("FAIL hold_single_step state=%b want 00010", state); end
    step_btn = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (state !== 5'b00010) begin errors++; $display("FAIL release_no_step state=%b want 00010", state); end
  endtask

  task automatic test_full_op;
    do_reset();
    inputsw = 32'h7FFF_FFFF; do_step();
    checks++; if (state !== PH_B || a !== 32'h7FFF_FFFF) begin errors++; $display("FAIL load_a state=%b a=%h want 00010/7fffffff", state, a); end
    inputsw = 32'h1; do_step();
    checks++; if (state !== PH_OP || b !== 32'h1) begin errors++; $display("FAIL load_b state=%b b=%h want 00100/1", state, b); end
    inputsw = 32'h2;
    exp_q.push_back('{res: 32'h8000_0000, flags: 4'b1010});
    do_step();
    checks++; if (state !== PH_RES || op !== 4'h2) begin errors++; $display("FAIL load_op state=%b op=%h want 01000/2", state, op); end
    checks++; if (res_valid !== 1'b0 || display !== '0) begin errors++; $display("FAIL res_entry v=%b disp=%h want 0/0", res_valid, display); end
    @(negedge clk);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL capture_latency v=%b want 1", res_valid); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL scoreboard_empty size=0 want 1"); end
    else begin
      cur = exp_q.pop_front();
      if (display !== cur.res) begin errors++; $display("FAIL result_display got %h want %h", display, cur.res); end
    end
  endtask

  task automatic test_freeze;
    inputsw = 32'hFFFF_FFFF; ovr = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (a !== 32'h7FFF_FFFF || b !== 32'h1 || op !== 4'h2) begin errors++; $display("FAIL freeze_res a=%h b=%h op=%h want 7fffffff/1/2", a, b, op); end
    checks++; if (display !== cur.res || res_valid !== 1'b1) begin errors++; $display("FAIL res_hold disp=%h v=%b want %h/1", display, res_valid, cur.res); end
    do_step();
    checks++; if (state !== PH_FLAGS || display !== {28'h0, cur.flags}) begin errors++; $display("FAIL flags_display state=%b disp=%h want 10000/%h", state, display, cur.flags); end
    repeat (3) @(negedge clk);
    checks++; if (display !== {28'h0, cur.flags} || a !== 32'h7FFF_FFFF || res_valid !== 1'b1) begin errors++; $display("FAIL freeze_flags disp=%h a=%h v=%b", display, a, res_valid); end
    do_step();
    checks++; if (state !== PH_A || res_valid !== 1'b0) begin errors++; $display("FAIL back_to_a state=%b v=%b want 00001/0", state, res_valid); end
    @(negedge clk);
    checks++; if (a !== 32'hFFFF_FFFF || display !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reedit_a a=%h disp=%h want ffffffff", a, display); end
    ovr = 1'b0;
  endtask

  task automatic test_async_reset;
    do_reset();
    inputsw = 32'h11; do_step();
    inputsw = 32'h22; do_step();
    inputsw = 32'h3;
    repeat (8) @(negedge clk);
    checks++; if (state !== PH_OP || op !== 4'h3) begin errors++; $display("FAIL pre_reset state=%b op=%h want 00100/3", state, op); end
    step_btn = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (state !== 5'b00001 || {a, b, op} !== '0) begin errors++; $display("FAIL async_reset state=%b a=%h b=%h op=%h want 00001/0", state, a, b, op); end
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (state !== 5'b00001) begin errors++; $display("FAIL stale_level_early state=%b want 00001", state); end
    @(negedge clk);
    checks++; if (state !== 5'b00010) begin errors++; $display("FAIL stale_level_step state=%b want 00010", state); end
    step_btn = 1'b0;
  endtask

  task automatic test_illegal;
    do_reset();
    inputsw = 32'h5; do_step();
    repeat (2) @(negedge clk);
    force dut.state_r = 5'b00110;
    #1 release dut.state_r;
    #1;
    checks++; if (state !== 5'b00110) begin errors++; $display("FAIL illegal_inject state=%b want 00110", state); end
    @(negedge clk);
    checks++; if (state !== 5'b00001 || res_valid !== 1'b0) begin errors++; $display("FAIL illegal_recover state=%b v=%b want 00001/0", state, res_valid); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] xs[4];
    logic [W-1:0] ys[4];
    logic [3:0]   os[4];
    logic [W-1:0] r;
    xs = '{32'h1234_5678, 32'hF0F0_F0F0, 32'h8000_0000, 32'hFFFF_FFFF};
    ys = '{32'h1234_5678, 32'h0FF0_0FF0, 32'h8000_0000, 32'h0000_0001};
    os = '{4'd3, 4'd0, 4'd2, 4'd4};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      inputsw = xs[i]; do_step();
      checks++; if (state !== PH_B || a !== xs[i]) begin errors++; $display("FAIL b2b_a[%0d] state=%b a=%h want %h", i, state, a, xs[i]); end
      inputsw = ys[i]; do_step();
      checks++; if (state !== PH_OP || b !== ys[i]) begin errors++; $display("FAIL b2b_b[%0d] state=%b b=%h want %h", i, state, b, ys[i]); end
      r = $urandom;
      inputsw = {r[W-1:4], os[i]};
      exp_q.push_back(alu_model(xs[i], ys[i], os[i]));
      do_step();
      checks++; if (state !== PH_RES || op !== os[i]) begin errors++; $display("FAIL b2b_op[%0d] state=%b op=%h want %h", i, state, op, os[i]); end
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_scoreboard_empty[%0d]", i); end
      else begin
        cur = exp_q.pop_front();
        if (res_valid !== 1'b1 || display !== cur.res) begin errors++; $display("FAIL b2b_res[%0d] v=%b disp=%h want 1/%h", i, res_valid, display, cur.res); end
      end
      do_step();
      checks++; if (state !== PH_FLAGS || display !== {28'h0, cur.flags}) begin errors++; $display("FAIL b2b_flags[%0d] disp=%h want %h", i, display, cur.flags); end
      do_step();
      checks++; if (state !== PH_A || res_valid !== 1'b0) begin errors++; $display("FAIL b2b_wrap[%0d] state=%b v=%b", i, state, res_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_full_op();
    test_freeze();
    test_async_reset();
    test_illegal();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_step_controller.md
Name: alu_step_controller

Overview:
- Operator-facing sequencer for the 32-bit ALU demo. A single debounced step pushbutton walks the operator through five phases: edit A, edit B, edit op, show result, show flags.
- Drives the ALU operand and op registers, captures the ALU result and flags once per operation, and selects the value for the display/LED logic.
- Replaces free-running per-clock state advance with button-paced, glitch-free stepping.

Parameters:
- Width, 32, operand/result/switch width.
- DebounceCycles, 1000000, consecutive clk cycles a synchronized button level must hold before it is accepted (>=2). Counter width is $clog2(DebounceCycles).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- step_btn  in  1  raw pushbutton, asynchronous to clk, active-high.
- inputsw  in  Width  switch bank.
- alu_result  in  Width  combinational ALU result from a, b, op.
- alu_flags  in  4  combinational ALU flags {overflow, carry, negative, zero}.
- a  out  Width  ALU operand A.
- b  out  Width  ALU operand B.
- op  out  4  ALU opcode.
- res_valid  out  1  captured result/flags are valid for the current a/b/op.
- display  out  Width  value for the display.
- state  out  5  one-hot phase {FLAGS, RES, OP, B, A}; bit 0 is A.

Behaviour:
- Reset, asynchronous:
  - state = A (5'b00001); a = b = 0; op = 0; res_reg = 0; flags_reg = 0; res_valid = 0.
  - Synchronizer flops = 0; debounce counter = 0; stable level = 0; stable_prev = 0.
  - Reset asserted mid-debounce or mid-phase discards everything; there are no partial updates.
- Button path:
  - 2-FF synchronizer produces sync_btn.
  - If sync_btn != stable: count increments each cycle. When count == DebounceCycles-1, stable <= sync_btn and count <= 0.
  - If sync_btn == stable: count <= 0, so glitches shorter than DebounceCycles are rejected.
  - step = stable & ~stable_prev, where stable_prev is a register. step is high for exactly one cycle per accepted press.
  - Holding the button gives one step. Release also needs DebounceCycles stable cycles and produces no step.
- Phases (advance only on step):
  - A -> B -> OP -> RES -> FLAGS -> A.
  - Illegal or non-one-hot state recovers to A on the next edge.
- Register updates:
  - In A, a <= inputsw every cycle (live edit); a is frozen in all other phases.
  - In B, b <= inputsw every cycle.
  - In OP, op <= inputsw[3:0] every cycle.
  - A step occurring in the same cycle as an edit still loads that cycle's inputsw, then freezes.
- Capture:
  - On the first clock edge while state == RES with res_valid == 0: res_reg <= alu_result, flags_reg <= alu_flags, res_valid <= 1.
  - This gives 1-cycle latency from entering RES. Operands are already registered, so the combinational ALU has a full cycle to settle.
  - A step arriving on RES entry's first cycle still captures before leaving.
  - res_valid clears on entering A (any edit invalidates the result). It stays 1 through RES and FLAGS.
- Display (combinational from registered state):
  - A: a.
  - B: b.
  - OP: zero-extended op.
  - RES: res_reg when res_valid, else 0.
  - FLAGS: zero-extended flags_reg.
- There are no other outputs and no ALU arithmetic in this block.

Decomposition:
- Shared package/include:
  - one-hot phase constants PH_A..PH_FLAGS;
  - flag bit indices FLAG_ZERO=0, FLAG_NEG=1, FLAG_CARRY=2, FLAG_OVF=3;
  - opcode width constant 4.
- Sub-module button_debouncer (synchronizer + counter + stable level + one-cycle rise pulse), parameterized by DebounceCycles. Reused for other board buttons.
- Controller FSM, operand/result registers and display mux stay in alu_step_controller.

Test Plan (DebounceCycles=4, Width=32):
- Reset then idle: all outputs 0, state=00001, display=0. Drive inputsw=32'h0000_00AA and hold → a=AA and display=AA one cycle later.
- Bounce rejection: pulse step_btn high 3 cycles, low, repeat 5 times → no step, state stays 00001. Hold high 10 cycles → exactly one step, state=00010 at 2+4+1(+1 for step register) cycles after rise. Holding longer gives no second step.
- Full operation:
  - Load a=32'h7FFF_FFFF, step; b=32'h1, step; op=4'h2 (ADD), step.
  - ALU model returns 32'h8000_0000, flags 4'b1010 → in RES, res_valid=1 one cycle after entry, display=32'h8000_0000.
  - Step → display=32'h0000_000A.
- Freeze check: change inputsw to 32'hFFFF_FFFF while in RES/FLAGS → a, b and op unchanged, res_reg unchanged. Step back to A → res_valid=0 and a=FFFF_FFFF.
- Async reset asserted mid-debounce (count=2) while in OP → immediately state=00001, a=b=op=0. After release, the stale button level needs a full 4-cycle hold to step.
- Force illegal state 5'b00110 (bench force) → state=00001 next edge, no spurious capture.
